// File: rtl/tage_multi_lfsr.sv
// Multi-channel pseudo-random source for the TAGE predictor frontend.
// Each channel is an independent maximal-length Fibonacci LFSR with its own
// advance enable, a configurable number of shifts per advance, runtime
// reseeding (zero seeds are replaced by the channel's reset value), a lockup
// guard that recovers an all-zero state, and a probability-gated chance output.
module tage_multi_lfsr #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 16,
  parameter int NBITS     = 2,
  parameter int STEP      = 1,
  parameter int PROB_BITS = 3,
  parameter int unsigned SEED = 1,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NCH-1:0]         en_i,
  input  logic                   seed_valid_i,
  input  logic [CHW-1:0]         seed_ch_i,
  input  logic [WIDTH-1:0]       seed_i,
  output logic [NCH*NBITS-1:0]   rand_o,
  output logic [NCH-1:0]         chance_o,
  output logic                   seed_zero_o
);

  typedef logic [NCH-1:0][WIDTH-1:0] state_arr_t;

  // Feedback tap masks; bit k-1 set means tap k participates in the XOR.
  localparam logic [31:0] TAPS_FULL = (WIDTH == 4)  ? 32'h0000_000C :
                                      (WIDTH == 8)  ? 32'h0000_00B8 :
                                      (WIDTH == 16) ? 32'h0000_D008 :
                                                      32'h8020_0003;
  localparam logic [WIDTH-1:0] TAPS   = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("tage_multi_lfsr: WIDTH must be 4, 8, 16 or 32");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("tage_multi_lfsr: SEED must be non-zero within WIDTH bits");
  end

  // Channel c resets to the seed rotated left by c, so channels start apart
  // and every reset value stays non-zero.
  function automatic state_arr_t reset_states();
    state_arr_t  r;
    int unsigned sh;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      sh   = c % WIDTH;
      r[c] = (SEED_W << sh) | (SEED_W >> ((WIDTH - sh) % WIDTH));
    end
    return r;
  endfunction

  localparam state_arr_t RST_STATE = reset_states();

  // One Fibonacci shift: feedback enters at the LSB.
  function automatic logic [WIDTH-1:0] lfsr_shift(input logic [WIDTH-1:0] q);
    return {q[WIDTH-2:0], ^(q & TAPS)};
  endfunction

  state_arr_t state_q, state_d;
  logic       seed_zero_q, seed_zero_d;

  // Next state per channel: seed load beats lockup recovery, which beats enable.
  always_comb begin
    logic [WIDTH-1:0] adv;
    state_d     = state_q;
    seed_zero_d = 1'b0;
    adv         = '0;
    for (int c = 0; c < NCH; c++) begin
      adv = state_q[c];
      for (int s = 0; s < STEP; s++) begin
        adv = lfsr_shift(adv);
      end
      if (seed_valid_i && (int'(seed_ch_i) == c)) begin
        if (seed_i == '0) begin
          state_d[c]  = RST_STATE[c];
          seed_zero_d = 1'b1;
        end else begin
          state_d[c] = seed_i;
        end
      end else if (state_q[c] == '0) begin
        state_d[c] = RST_STATE[c];
      end else if (en_i[c]) begin
        state_d[c] = adv;
      end
    end
  end

  // State and zero-seed pulse registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RST_STATE;
      seed_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_zero_q <= seed_zero_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign rand_o[c*NBITS +: NBITS] = state_q[c][WIDTH-1 -: NBITS];
    assign chance_o[c]              = (state_q[c][WIDTH-1 -: PROB_BITS] == '0);
  end

  assign seed_zero_o = seed_zero_q;

endmodule
